dfmul_key_run_ctrl: RTL

DFMUL_KEY_RUN_CTRL -- requirements
Module: dfmul_key_run_ctrl

---
 rtl/dfmul_lock_pkg.sv | 16 +
 rtl/dfmul_key_shifter.sv | 63 ++++++
 rtl/dfmul_key_run_ctrl.sv | 97 +++++++++
 3 files changed

// File: rtl/dfmul_lock_pkg.sv
// Shared definitions for the locked-core key loader and run controller.
// Optional DFMUL_KEY_PARITY_EN appends an even-parity bit to the key shift.
package dfmul_lock_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_COMMIT,
        ST_RUN,
        ST_REPORT
    } lock_state_e;

    localparam int          KEY_WIDTH_DEF    = 32;
    localparam logic [31:0] TIMEOUT_SENTINEL = 32'hFFFF_FFFF;

endpackage

// File: rtl/dfmul_key_shifter.sv
// Serial key shadow register, bit counter and commit into working_key.
// With DFMUL_KEY_PARITY_EN one extra even-parity bit is shifted and checked on commit.
module dfmul_key_shifter
    import dfmul_lock_pkg::*;
#(
    parameter int KEY_WIDTH = KEY_WIDTH_DEF
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 clr,
    input  logic                 shift_en,
    input  logic                 sdi,
    input  logic                 commit,
    output logic                 last_bit,
    output logic [KEY_WIDTH-1:0] working_key,
    output logic                 key_loaded
);

`ifdef DFMUL_KEY_PARITY_EN
    localparam int SH_W = KEY_WIDTH + 1;
`else
    localparam int SH_W = KEY_WIDTH;
`endif
    localparam int CW = $clog2(SH_W + 1);

    logic [SH_W-1:0] shadow;
    logic [CW-1:0]   cnt;

    // High while the next accepted bit is the final one of the frame.
    assign last_bit = (cnt == CW'(SH_W - 1));

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            shadow      <= '0;
            cnt         <= '0;
            working_key <= '0;
            key_loaded  <= 1'b0;
        end else begin
            if (clr) begin
                shadow <= '0;
                cnt    <= '0;
            end else if (shift_en) begin
                shadow <= {shadow[SH_W-2:0], sdi};
                cnt    <= cnt + CW'(1);
            end
            if (commit) begin
`ifdef DFMUL_KEY_PARITY_EN
                // Key plus parity bit must XOR to zero; otherwise keep the old key but disarm.
                if (^shadow == 1'b0) begin
                    working_key <= shadow[SH_W-1:1];
                    key_loaded  <= 1'b1;
                end else begin
                    key_loaded  <= 1'b0;
                end
`else
                working_key <= shadow;
                key_loaded  <= 1'b1;
`endif
            end
        end
    end

endmodule

// File: rtl/dfmul_key_run_ctrl.sv
// Key load / locked-core run controller: serial key commit, ap_ctrl_hs run, timeout.
// Optional DFMUL_KEY_PARITY_EN (handled in dfmul_key_shifter) adds key parity checking.
module dfmul_key_run_ctrl
    import dfmul_lock_pkg::*;
#(
    parameter int KEY_WIDTH      = KEY_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                 ap_clk,
    input  logic                 ap_rst,
    input  logic                 key_load,
    input  logic                 key_sen,
    input  logic                 key_sdi,
    input  logic                 run_start,
    output logic [KEY_WIDTH-1:0] working_key,
    output logic                 core_ap_start,
    input  logic                 core_ap_done,
    input  logic [31:0]          core_ap_return,
    output logic                 key_loaded,
    output logic                 busy,
    output logic                 result_valid,
    output logic                 result_pass,
    output logic                 result_timeout,
    output logic [31:0]          result_count
);

    localparam logic [15:0] RUN_LAST = 16'(TIMEOUT_CYCLES - 1);

    lock_state_e state;
    logic [15:0] run_cnt;
    logic        sh_clr, sh_en, sh_last;

    // key_load restarts a shift from IDLE or mid-SHIFT and wins over a data bit.
    assign sh_clr = key_load & ((state == ST_IDLE) | (state == ST_SHIFT));
    assign sh_en  = (state == ST_SHIFT) & key_sen & ~key_load;
    assign busy   = (state != ST_IDLE);

    dfmul_key_shifter #(.KEY_WIDTH(KEY_WIDTH)) u_shifter (
        .ap_clk      (ap_clk),
        .ap_rst      (ap_rst),
        .clr         (sh_clr),
        .shift_en    (sh_en),
        .sdi         (key_sdi),
        .commit      (state == ST_COMMIT),
        .last_bit    (sh_last),
        .working_key (working_key),
        .key_loaded  (key_loaded)
    );

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state          <= ST_IDLE;
            run_cnt        <= '0;
            core_ap_start  <= 1'b0;
            result_valid   <= 1'b0;
            result_pass    <= 1'b0;
            result_timeout <= 1'b0;
            result_count   <= '0;
        end else begin
            result_valid <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (key_load) begin
                        state <= ST_SHIFT;
                    end else if (run_start && key_loaded) begin
                        state         <= ST_RUN;
                        run_cnt       <= '0;
                        core_ap_start <= 1'b1;
                    end
                end
                ST_SHIFT: if (sh_en && sh_last) state <= ST_COMMIT;
                ST_COMMIT: state <= ST_IDLE;
                ST_RUN: begin
                    if (run_cnt != 16'hFFFF) run_cnt <= run_cnt + 16'd1;
                    if (core_ap_done) begin
                        state          <= ST_REPORT;
                        core_ap_start  <= 1'b0;
                        result_valid   <= 1'b1;
                        result_count   <= core_ap_return;
                        result_pass    <= (core_ap_return == 32'd0);
                        result_timeout <= 1'b0;
                    end else if (run_cnt >= RUN_LAST) begin
                        state          <= ST_REPORT;
                        core_ap_start  <= 1'b0;
                        result_valid   <= 1'b1;
                        result_count   <= TIMEOUT_SENTINEL;
                        result_pass    <= 1'b0;
                        result_timeout <= 1'b1;
                    end
                end
                ST_REPORT: state <= ST_IDLE;
                default:   state <= ST_IDLE;
            endcase
        end
    end

endmodule
